deserializer_stream: RTL and testbench
======================================

Name: deserializer_stream

Overview:
- Parametrised serial-to-parallel converter. Accepts LANES bits per beat over a valid/ready handshake and assembles WORD_W-bit words.
- Selectable bit order (LSB-first or MSB-first).
- Completed words are buffered in an OUT_DEPTH-entry output FIFO, so collection continues while the downstream consumer (e.g. the FIR) stalls.
- Sits between the serial stimulus/link and the FIR filter input.

Parameters:
- WORD_W, 24: output word width; must be a multiple of LANES.
- LANES, 1: bits accepted per input beat; must be 1 or more.
- MSB_FIRST, 0: 0 means the first beat lands in the least significant bits; 1 means it lands in the most significant bits.
- OUT_DEPTH, 2: output FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  clock enable; when low, all state freezes.
- iv_din  in  LANES  serial data beat.
- i_din_valid  in  1  iv_din is valid.
- o_din_ready  out  1  block accepts a beat this cycle.
- ov_dout  out  WORD_W  assembled word at the FIFO head.
- o_dout_valid  out  1  ov_dout is valid (FIFO not empty).
- i_dout_ready  in  1  consumer takes the head word.
- ov_fill  out  clog2(OUT_DEPTH+1)  number of words held in the FIFO.
- o_busy  out  1  a word is partially collected (beat_cnt != 0).

Behaviour:
- Definitions:
  - BEATS = WORD_W/LANES.
  - Input transfer (in_xfer) = i_en & i_din_valid & o_din_ready.
  - Output transfer (out_xfer) = i_en & o_dout_valid & i_dout_ready.
- Handshake outputs:
  - o_din_ready = i_en & (fill < OUT_DEPTH). This is combinational from registered fill only.
  - o_din_ready does not depend on i_din_valid, and does not depend on a same-cycle pop.
- Reset (i_rst=1 at a clock edge, regardless of i_en):
  - beat_cnt=0, shift register=0, FIFO pointers=0, fill=0.
  - o_dout_valid=0, ov_dout=0, o_busy=0, FSM=IDLE.
  - Reset mid-word discards the partial word and all buffered words.
- FSM states:
  - IDLE (beat_cnt=0): an in_xfer captures beat 0 and moves to COLLECT. If BEATS=1, the word is pushed to the FIFO and the FSM stays in IDLE.
  - COLLECT: each in_xfer increments beat_cnt. The in_xfer with beat_cnt=BEATS-1 pushes the completed word, clears beat_cnt and returns to IDLE.
  - Cycles with no in_xfer hold state, counter and data. There is no timeout.
- Bit order:
  - MSB_FIRST=0: the shift register shifts right by LANES and iv_din enters at the top. Beat k ends in bits [k*LANES +: LANES].
  - MSB_FIRST=1: the shift register shifts left by LANES and iv_din enters at the bottom. Beat k ends in bits [(BEATS-1-k)*LANES +: LANES].
  - Bit order within a beat is always preserved (iv_din[0] maps to the lower bit).
- Push path:
  - The completed word written to the FIFO includes the final beat, formed combinationally from the shift register and iv_din.
  - The word is visible on ov_dout with o_dout_valid=1 on the cycle after the last beat's clock edge (latency 1).
- FIFO:
  - Head data is registered or read combinationally from storage.
  - ov_dout shows the head word when fill>0 and 0 when empty.
  - Push and pop in the same cycle: fill is unchanged and both pointers advance. This is legal whenever fill>0.
  - Pointers wrap modulo OUT_DEPTH.
  - Overflow is impossible: no push occurs at fill=OUT_DEPTH because o_din_ready=0.
  - Pop at empty is ignored.
- i_en=0: no transfers, no state change. Outputs hold their registered values, except o_din_ready, which is 0.
- o_busy = (beat_cnt != 0).

Test Plan:
- Single-lane LSB-first: WORD_W=24, LANES=1, MSB_FIRST=0, i_dout_ready=1; send 0xA5C3F0 bit0 first over 24 consecutive beats -> ov_dout=0xA5C3F0 with o_dout_valid=1 for exactly one cycle, on the cycle after the 24th beat; ov_fill returns to 0.
- MSB-first multi-lane: LANES=4, MSB_FIRST=1; send nibbles 1,2,3,4,5,6 -> ov_dout=0x123456 after 6 beats; o_busy=1 during beats 2-6 and 0 afterwards.
- Backpressure: OUT_DEPTH=2, i_dout_ready=0; stream words 0x000001, 0x000002, 0x000003 -> ov_fill reaches 2 and o_din_ready=0 with beat_cnt=0. Then raise i_dout_ready -> pops 0x000001, accepts the third word's beats, and delivers words in order 1, 2, 3 with no loss.
- Simultaneous push/pop: fill=1 with i_dout_ready=1 on the cycle the last beat of the next word is accepted -> ov_fill stays 1 and the head advances to the new word.
- Reset mid-word: after 10 beats of a 24-bit word, plus one buffered word, assert i_rst for 1 cycle -> o_dout_valid=0, ov_fill=0, o_busy=0; the next 24 beats of 0x00FFFF yield exactly 0x00FFFF.
- Enable gating: drop i_en for 5 cycles mid-word with i_din_valid=1 -> o_din_ready=0, no beats consumed; the word completes correctly once i_en returns.

Source files
------------

// File: rtl/deserializer_stream.sv
// Serial-to-parallel converter: collects LANES-bit beats into WORD_W-bit words
// and buffers completed words in a small output FIFO so the consumer may stall.
module deserializer_stream #(
  parameter int WORD_W    = 24,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0,
  parameter int OUT_DEPTH = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic [LANES-1:0]               iv_din,
  input  logic                           i_din_valid,
  output logic                           o_din_ready,
  output logic [WORD_W-1:0]              ov_dout,
  output logic                           o_dout_valid,
  input  logic                           i_dout_ready,
  output logic [$clog2(OUT_DEPTH+1)-1:0] ov_fill,
  output logic                           o_busy
);

  localparam int BEATS  = WORD_W / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int FILL_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   beat_cnt;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  word_next;
  logic [WORD_W-1:0]  mem [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FILL_W-1:0]  fill;
  logic               in_xfer;
  logic               out_xfer;
  logic               last_beat;
  logic               push;

  assign o_din_ready  = i_en & (fill < FILL_W'(OUT_DEPTH));
  assign o_dout_valid = (fill != '0);
  assign in_xfer      = i_en & i_din_valid & o_din_ready;
  assign out_xfer     = i_en & o_dout_valid & i_dout_ready;
  assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
  assign push         = in_xfer & last_beat;
  assign o_busy       = (beat_cnt != '0);
  assign ov_fill      = fill;
  assign ov_dout      = o_dout_valid ? mem[rd_ptr] : '0;

  // The shifted word including the current beat; on the last beat this is the word pushed.
  always_comb begin
    word_next = '0;
    if (MSB_FIRST != 0) begin
      word_next = (shreg << LANES) | WORD_W'(iv_din);
    end else begin
      word_next = (shreg >> LANES) | (WORD_W'(iv_din) << (WORD_W - LANES));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else if (i_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer && (BEATS > 1)) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt <= '0;
      shreg    <= '0;
    end else if (in_xfer) begin
      shreg    <= word_next;
      beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (out_xfer) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !out_xfer) begin
        fill <= fill + FILL_W'(1);
      end else if (out_xfer && !push) begin
        fill <= fill - FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_deserializer_stream.sv
// Scoreboard bench: two deserializer instances (1-lane LSB-first, 4-lane MSB-first)
// with expected words queued at stimulus time and checked by per-instance monitors.
module tb_deserializer_stream;

  logic        clk;
  logic        rst;
  logic        en;

  logic        din_a;
  logic        din_valid_a;
  logic        din_ready_a;
  logic [23:0] dout_a;
  logic        dout_valid_a;
  logic        dout_ready_a;
  logic [1:0]  fill_a;
  logic        busy_a;

  logic [3:0]  din_b;
  logic        din_valid_b;
  logic        din_ready_b;
  logic [23:0] dout_b;
  logic        dout_valid_b;
  logic        dout_ready_b;
  logic [1:0]  fill_b;
  logic        busy_b;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];

  deserializer_stream #(.WORD_W(24), .LANES(1), .MSB_FIRST(0), .OUT_DEPTH(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .iv_din(din_a), .i_din_valid(din_valid_a), .o_din_ready(din_ready_a),
    .ov_dout(dout_a), .o_dout_valid(dout_valid_a), .i_dout_ready(dout_ready_a),
    .ov_fill(fill_a), .o_busy(busy_a)
  );

  deserializer_stream #(.WORD_W(24), .LANES(4), .MSB_FIRST(1), .OUT_DEPTH(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .iv_din(din_b), .i_din_valid(din_valid_b), .o_din_ready(din_ready_b),
    .ov_dout(dout_b), .o_dout_valid(dout_valid_b), .i_dout_ready(dout_ready_b),
    .ov_fill(fill_b), .o_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitors pop the scoreboard whenever a word is handed to the consumer.
  always @(negedge clk) begin
    if (!rst && en && dout_valid_a && dout_ready_a) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL a_unexpected_word: got %0h, expected no word", dout_a);
      end else begin
        checkOutput("a_word", 32'(dout_a), 32'(exp_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && en && dout_valid_b && dout_ready_b) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL b_unexpected_word: got %0h, expected no word", dout_b);
      end else begin
        checkOutput("b_word", 32'(dout_b), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic send_beats(input bit use_b, input logic [23:0] word, input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      int guard;
      @(negedge clk);
      if (use_b) begin
        din_b       = word[(5-k)*4 +: 4];
        din_valid_b = 1'b1;
      end else begin
        din_a       = word[k];
        din_valid_a = 1'b1;
      end
      #1;
      guard = 0;
      while (!(use_b ? din_ready_b : din_ready_a) && guard < 100) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 100) begin
        tests++;
        fails++;
        $display("[TB] FAIL beat_accept: got ready=0 for 100 cycles, expected ready=1");
      end
      @(posedge clk);
      #1;
    end
    din_valid_a = 1'b0;
    din_valid_b = 1'b0;
  endtask

  task automatic applyStimulus(input bit use_b, input logic [23:0] word);
    if (use_b) exp_b.push_back(word);
    else       exp_a.push_back(word);
    send_beats(use_b, word, 0, use_b ? 6 : 24);
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    checkOutput(name, 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    din_a = 1'b0; din_valid_a = 1'b0; dout_ready_a = 1'b0;
    din_b = 4'h0; din_valid_b = 1'b0; dout_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    checkOutput("rst_valid", 32'(dout_valid_a), 32'd0);
    checkOutput("rst_dout",  32'(dout_a),       32'd0);
    checkOutput("rst_fill",  32'(fill_a),       32'd0);
    checkOutput("rst_busy",  32'(busy_a),       32'd0);
    checkOutput("rst_ready", 32'(din_ready_a),  32'd1);

    // Single-lane LSB-first, word valid for exactly one cycle
    dout_ready_a = 1'b1;
    applyStimulus(1'b0, 24'hA5C3F0);
    checkOutput("lsb_valid_after_last", 32'(dout_valid_a), 32'd1);
    checkOutput("lsb_dout",             32'(dout_a),       32'hA5C3F0);
    checkOutput("lsb_fill_one",         32'(fill_a),       32'd1);
    @(posedge clk); #1;
    checkOutput("lsb_valid_one_cycle",  32'(dout_valid_a), 32'd0);
    checkOutput("lsb_fill_zero",        32'(fill_a),       32'd0);

    // MSB-first, 4 lanes
    dout_ready_b = 1'b1;
    exp_b.push_back(24'h123456);
    send_beats(1'b1, 24'h123456, 0, 1);
    checkOutput("msb_busy_beat2", 32'(busy_b), 32'd1);
    send_beats(1'b1, 24'h123456, 1, 5);
    checkOutput("msb_busy_beat6", 32'(busy_b), 32'd1);
    send_beats(1'b1, 24'h123456, 5, 6);
    checkOutput("msb_busy_done", 32'(busy_b), 32'd0);
    checkOutput("msb_dout",      32'(dout_b), 32'h123456);
    wait_drain("msb_drain");

    // Backpressure fills the FIFO, then drains in order
    dout_ready_a = 1'b0;
    applyStimulus(1'b0, 24'h000001);
    applyStimulus(1'b0, 24'h000002);
    checkOutput("bp_fill_full", 32'(fill_a),      32'd2);
    checkOutput("bp_ready_low", 32'(din_ready_a), 32'd0);
    checkOutput("bp_busy_idle", 32'(busy_a),      32'd0);
    checkOutput("bp_head",      32'(dout_a),      32'h000001);
    dout_ready_a = 1'b1;
    applyStimulus(1'b0, 24'h000003);
    wait_drain("bp_drain");
    checkOutput("bp_fill_empty", 32'(fill_a), 32'd0);

    // Simultaneous push and pop at fill=1
    dout_ready_a = 1'b0;
    applyStimulus(1'b0, 24'h111111);
    exp_a.push_back(24'hC0FFEE);
    send_beats(1'b0, 24'hC0FFEE, 0, 23);
    checkOutput("pp_fill_before", 32'(fill_a), 32'd1);
    dout_ready_a = 1'b1;
    send_beats(1'b0, 24'hC0FFEE, 23, 24);
    checkOutput("pp_fill_same", 32'(fill_a), 32'd1);
    checkOutput("pp_head_new",  32'(dout_a), 32'hC0FFEE);
    wait_drain("pp_drain");

    // Reset mid-word with a buffered word
    dout_ready_a = 1'b0;
    applyStimulus(1'b0, 24'h0000AA);
    send_beats(1'b0, 24'h123456, 0, 10);
    checkOutput("rm_busy_before", 32'(busy_a), 32'd1);
    checkOutput("rm_fill_before", 32'(fill_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rm_valid", 32'(dout_valid_a), 32'd0);
    checkOutput("rm_fill",  32'(fill_a),       32'd0);
    checkOutput("rm_busy",  32'(busy_a),       32'd0);
    checkOutput("rm_dout",  32'(dout_a),       32'd0);
    dout_ready_a = 1'b1;
    applyStimulus(1'b0, 24'h00FFFF);
    wait_drain("rm_drain");

    // Enable gating mid-word with valid held high
    exp_a.push_back(24'h5A5A5A);
    send_beats(1'b0, 24'h5A5A5A, 0, 10);
    @(negedge clk);
    en = 1'b0;
    din_a = 1'b1;
    din_valid_a = 1'b1;
    #1;
    checkOutput("en_ready_low", 32'(din_ready_a), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("en_busy_held", 32'(busy_a), 32'd1);
    checkOutput("en_fill_held", 32'(fill_a), 32'd0);
    en = 1'b1;
    send_beats(1'b0, 24'h5A5A5A, 10, 24);
    wait_drain("en_drain");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_fill_a", 32'(fill_a), 32'd0);
    checkOutput("final_fill_b", 32'(fill_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
